// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and output clamp limits for the FIR MAC sequencer.
package fir_pkg;

    localparam int unsigned N_TAPS = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned FRAC   = 15;
    localparam int unsigned ACC_W  = 40;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up by FRAC bits, then clamp the accumulator into a DATA_W signed sample.
module fir_round_sat #(
    parameter int unsigned ACC_W  = fir_pkg::ACC_W,
    parameter int unsigned DATA_W = fir_pkg::DATA_W,
    parameter int unsigned FRAC   = fir_pkg::FRAC
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);

    import fir_pkg::*;

    // One guard bit so adding the half-LSB can never overflow.
    localparam int unsigned RW = ACC_W + 1;

    // Package limits cover the default width; other widths derive their own.
    localparam longint HI_L = (DATA_W == fir_pkg::DATA_W) ? longint'(SAT_MAX)
                                                          : (longint'(1) <<< (DATA_W - 1)) - longint'(1);
    localparam longint LO_L = (DATA_W == fir_pkg::DATA_W) ? longint'(SAT_MIN)
                                                          : -(longint'(1) <<< (DATA_W - 1));

    localparam logic signed [RW-1:0] HALF = RW'(longint'(1) <<< (FRAC - 1));
    localparam logic signed [RW-1:0] HI   = RW'(HI_L);
    localparam logic signed [RW-1:0] LO   = RW'(LO_L);

    logic signed [RW-1:0] r;
    logic signed [RW-1:0] q;

    // Add half an output LSB, arithmetic shift, then clamp instead of wrapping.
    always_comb begin
        r = RW'(acc) + HALF;
        q = r >>> FRAC;
        if (q > HI) begin
            y = HI[DATA_W-1:0];
        end else if (q < LO) begin
            y = LO[DATA_W-1:0];
        end else begin
            y = q[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one sample in, N_TAPS serial MAC cycles, one rounded/saturated sample out.
module fir_mac_sequencer #(
    parameter int unsigned N_TAPS = fir_pkg::N_TAPS,
    parameter int unsigned DATA_W = fir_pkg::DATA_W,
    parameter int unsigned COEF_W = fir_pkg::COEF_W,
    parameter int unsigned FRAC   = fir_pkg::FRAC,
    parameter int unsigned ACC_W  = fir_pkg::ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    x_in,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    output logic                        out_valid,
    output logic signed [DATA_W-1:0]    y_out,
    output logic                        busy
);

    import fir_pkg::*;

    localparam int unsigned AW = $clog2(N_TAPS);
    localparam int unsigned PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

    state_t state;
    state_t state_next;

    logic accept_c;
    logic mac_c;
    logic coef_wr_c;
    logic done_c;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cur;
    logic [AW-1:0] tap;
    logic [AW-1:0] rd_idx;

    logic signed [DATA_W-1:0] dline [N_TAPS];
    logic signed [COEF_W-1:0] coef  [N_TAPS];

    logic signed [ACC_W-1:0]  acc;
    logic signed [PW-1:0]     prod;
    logic signed [DATA_W-1:0] y_c;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        mac_c      = 1'b0;
        coef_wr_c  = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                coef_wr_c = coef_we;
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_c = 1'b1;
                if (tap == LAST_TAP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Coefficient RAM; writes land only while idle, including the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr_c) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Circular delay line and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                dline[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (accept_c) begin
            dline[wr_ptr] <= x_in;
            wr_ptr        <= wr_ptr + AW'(1);
        end
    end

    // Tap product: newest sample pairs with h[0], walking backwards through the ring.
    always_comb begin
        rd_idx = cur - tap;
        prod   = PW'(coef[tap]) * PW'(dline[rd_idx]);
    end

    // Shared accumulator and tap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cur <= '0;
            tap <= '0;
        end else if (accept_c) begin
            acc <= '0;
            cur <= wr_ptr;
            tap <= '0;
        end else if (mac_c) begin
            acc <= acc + ACC_W'(prod);
            tap <= tap + AW'(1);
        end
    end

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_round_sat (
        .acc (acc),
        .y   (y_c)
    );

    // Registered handshake/status flags and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= done_c;
            if (done_c) begin
                y_out <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with hand-computed expected outputs.
module tb_fir_mac_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               out_valid;
    logic signed [15:0] y_out;
    logic               busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y_out     (y_out),
        .busy      (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_coef(input logic [2:0] k, input logic signed [15:0] v);
        coef_we   = 1'b1;
        coef_addr = k;
        coef_data = v;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Offers one sample from IDLE; lat counts cycles from the accept edge to the out_valid cycle.
    task automatic run_sample(input logic signed [15:0] x, input bit cw_same, input bit cw_busy,
                              input logic [2:0] ca, input logic signed [15:0] cd,
                              output logic signed [15:0] y, output int lat, output logic ov_after);
        in_valid = 1'b1;
        x_in     = x;
        if (cw_same || cw_busy) begin
            coef_addr = ca;
            coef_data = cd;
        end
        coef_we = cw_same;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat = -1;
        y   = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cw_busy) coef_we = (k == 3);
            if (out_valid) begin
                lat = k + 1;
                y   = y_out;
                break;
            end
        end
        coef_we = 1'b0;
        @(negedge clk);
        ov_after = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        tests++; if (y_out !== 16'sd0) begin fails++; $display("FAIL reset y_out: got %0d want 0", y_out); end
    endtask

    task automatic test_impulse();
        logic signed [15:0] e [8] = '{16'sd8192, 16'sd4096, 16'sd2048, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] y;
        int lat;
        logic ova;
        do_reset();
        wr_coef(3'd0, 16'sd16384);
        wr_coef(3'd1, 16'sd8192);
        wr_coef(3'd2, 16'sd4096);
        for (int i = 0; i < 8; i++) begin
            run_sample((i == 0) ? 16'sd16384 : 16'sd0, 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
            tests++; if (y !== e[i]) begin fails++; $display("FAIL impulse y[%0d]: got %0d want %0d", i, y, e[i]); end
            tests++; if (lat !== 10) begin fails++; $display("FAIL impulse latency[%0d]: got %0d want 10", i, lat); end
            tests++; if (ova !== 1'b0) begin fails++; $display("FAIL impulse pulse width[%0d]: out_valid %b want 0", i, ova); end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] y;
        int lat;
        logic ova;
        bit wrapped = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(3'(k), 16'sd32767);
        for (int i = 0; i < 8; i++) begin
            run_sample(16'sd32767, 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
            if (y < 0) wrapped = 1'b1;
        end
        tests++; if (y !== 16'sd32767) begin fails++; $display("FAIL sat positive: got %0d want 32767", y); end
        tests++; if (wrapped !== 1'b0) begin fails++; $display("FAIL sat positive wrap: negative output seen %b want 0", wrapped); end
        for (int i = 0; i < 8; i++) begin
            run_sample(-16'sd32768, 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
        end
        tests++; if (y !== -16'sd32768) begin fails++; $display("FAIL sat negative: got %0d want -32768", y); end
    endtask

    task automatic test_rounding();
        logic signed [15:0] xs [4] = '{16'sd16384, 16'sd16383, -16'sd16384, -16'sd16385};
        logic signed [15:0] e  [4] = '{16'sd1, 16'sd0, 16'sd0, -16'sd1};
        logic signed [15:0] y;
        int lat;
        logic ova;
        do_reset();
        wr_coef(3'd0, 16'sd1);
        for (int i = 0; i < 4; i++) begin
            run_sample(xs[i], 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
            tests++; if (y !== e[i]) begin fails++; $display("FAIL rounding x=%0d: got %0d want %0d", xs[i], y, e[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] xs [4] = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};
        logic signed [15:0] e  [4] = '{16'sd500, 16'sd1000, 16'sd1500, 16'sd2000};
        int acc_c [4];
        int nacc = 0;
        int nout = 0;
        bit adv = 1'b0;
        bit hs_bad = 1'b0;
        do_reset();
        wr_coef(3'd0, 16'sd16384);
        in_valid = 1'b1;
        x_in     = xs[0];
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                if (nacc < 4) x_in = xs[nacc];
                else in_valid = 1'b0;
            end
            if (in_ready === busy) hs_bad = 1'b1;
            if (out_valid) begin
                if (nout < 4) begin
                    tests++; if (y_out !== e[nout]) begin fails++; $display("FAIL b2b y[%0d]: got %0d want %0d", nout, y_out, e[nout]); end
                    tests++; if (c - acc_c[nout] !== 10) begin fails++; $display("FAIL b2b latency[%0d]: got %0d want 10", nout, c - acc_c[nout]); end
                end
                nout++;
            end
            if (in_valid && in_ready) begin
                if (nacc > 0) begin
                    tests++; if (c - acc_c[nacc-1] !== 10) begin fails++; $display("FAIL b2b accept spacing[%0d]: got %0d want 10", nacc, c - acc_c[nacc-1]); end
                end
                acc_c[nacc] = c;
                nacc++;
                adv = 1'b1;
            end
        end
        in_valid = 1'b0;
        tests++; if (nout !== 4) begin fails++; $display("FAIL b2b output count: got %0d want 4", nout); end
        tests++; if (nacc !== 4) begin fails++; $display("FAIL b2b accept count: got %0d want 4", nacc); end
        tests++; if (hs_bad !== 1'b0) begin fails++; $display("FAIL b2b in_ready/busy overlap: got %b want 0", hs_bad); end
    endtask

    task automatic test_coef_busy();
        logic signed [15:0] y;
        int lat;
        logic ova;
        do_reset();
        wr_coef(3'd0, 16'sd16384);
        run_sample(16'sd16384, 1'b0, 1'b1, 3'd0, 16'sd0, y, lat, ova);
        tests++; if (y !== 16'sd8192) begin fails++; $display("FAIL coef busy write current: got %0d want 8192", y); end
        run_sample(16'sd16384, 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
        tests++; if (y !== 16'sd8192) begin fails++; $display("FAIL coef busy write readback: got %0d want 8192", y); end
        run_sample(16'sd16384, 1'b1, 1'b0, 3'd0, 16'sd32767, y, lat, ova);
        tests++; if (y !== 16'sd16384) begin fails++; $display("FAIL coef same-edge write: got %0d want 16384", y); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [15:0] e [8] = '{16'sd8192, 16'sd4096, 16'sd2048, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] y;
        int lat;
        logic ova;
        bit seen = 1'b0;
        do_reset();
        wr_coef(3'd0, 16'sd16384);
        wr_coef(3'd1, 16'sd8192);
        wr_coef(3'd2, 16'sd4096);
        for (int i = 0; i < 6; i++) run_sample(16'sd16384, 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
        in_valid = 1'b1;
        x_in     = 16'sd16384;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (y_out !== 16'sd0) begin fails++; $display("FAIL abort y_out: got %0d want 0", y_out); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort in_ready: got %b want 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort out_valid pulsed: got %b want 0", seen); end
        wr_coef(3'd0, 16'sd16384);
        wr_coef(3'd1, 16'sd8192);
        wr_coef(3'd2, 16'sd4096);
        for (int i = 0; i < 8; i++) begin
            run_sample((i == 0) ? 16'sd16384 : 16'sd0, 1'b0, 1'b0, 3'd0, 16'sd0, y, lat, ova);
            tests++; if (y !== e[i]) begin fails++; $display("FAIL post-abort impulse y[%0d]: got %0d want %0d", i, y, e[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_coef_busy();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
